// File: rtl/multicycle_ctrl.sv
// Main sequencer for the multicycle RV32I core: drives the shared ALU, memory port,
// IR and register file across several cycles per instruction, with memory stalls and an illegal-opcode trap.
module multicycle_ctrl #(
  parameter bit FETCH_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11,
    S_IDLE     = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_mem_req;
  logic   w_pc_write;
  logic   w_mem_write;
  logic   w_ir_write;
  logic   w_reg_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FETCH_ON_RESET ? S_FETCH : S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // PC and IR only capture on the cycle the fetch actually completes.
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECR;
          7'b0010011:             w_next = S_EXECI;
          7'b1101111:             w_next = S_JAL;
          7'b1100011:             w_next = S_BRANCH;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_JAL: begin
        // ALUOut holds the target from DECODE; the ALU now forms OldPC+4 for rd.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        w_next    = S_FETCH;
        case (funct3)
          3'b000:  w_pc_write = zero;
          3'b001:  w_pc_write = ~zero;
          default: w_next = S_TRAP;
        endcase
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      7'b0000011, 7'b0010011: imm_src = 2'b00;
      7'b0100011:             imm_src = 2'b01;
      7'b1100011:             imm_src = 2'b10;
      7'b1101111:             imm_src = 2'b11;
      default:                imm_src = 2'b00;
    endcase
  end

  // Enables and requests are held off for the whole reset cycle regardless of mem_ready.
  assign mem_req       = rst_n & w_mem_req;
  assign pc_write      = rst_n & w_pc_write;
  assign mem_write     = rst_n & w_mem_write;
  assign ir_write      = rst_n & w_ir_write;
  assign reg_write     = rst_n & w_reg_write;
  assign illegal_instr = r_illegal;
  assign state_o       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: reset, lw, fetch stall, branches, R-type, jal, sw with waits, trap.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic       illegal_instr;
  logic [3:0] state_o;
  logic [5:0] en;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl #(.FETCH_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  // {mem_req, pc_write, adr_src, mem_write, ir_write, reg_write}
  assign en = {mem_req, pc_write, adr_src, mem_write, ir_write, reg_write};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = 7'b0000011; funct3 = 3'b000; zero = 1'b0;
    #1;
    check_eq("rst_en_pre", 8'(en), 8'h00);
    cyc();
    check_eq("rst_en_1", 8'(en), 8'h00);
    check_eq("rst_state", 8'(state_o), 8'd0);
    check_eq("rst_illegal", 8'(illegal_instr), 8'd0);
    cyc();
    check_eq("rst_en_2", 8'(en), 8'h00);
    rst_n = 1'b1;
    #1;
    check_eq("rel_state", 8'(state_o), 8'd0);
    check_eq("rel_mem_req", 8'(mem_req), 8'd1);

    // lw, no waits
    check_eq("lw_fetch_en", 8'(en), 8'b110010);
    check_eq("lw_fetch_rs", 8'(result_src), 8'b10);
    check_eq("lw_fetch_b", 8'(alu_src_b), 8'b10);
    cyc();
    check_eq("lw_s1", 8'(state_o), 8'd1);
    check_eq("lw_dec_en", 8'(en), 8'h00);
    check_eq("lw_dec_ab", 8'({alu_src_a, alu_src_b}), 8'b0101);
    check_eq("lw_imm", 8'(imm_src), 8'b00);
    cyc();
    check_eq("lw_s2", 8'(state_o), 8'd2);
    check_eq("lw_adr_ab", 8'({alu_src_a, alu_src_b}), 8'b1001);
    cyc();
    check_eq("lw_s3", 8'(state_o), 8'd3);
    check_eq("lw_rd_en", 8'(en), 8'b101000);
    cyc();
    check_eq("lw_s4", 8'(state_o), 8'd4);
    check_eq("lw_wb_en", 8'(en), 8'b000001);
    check_eq("lw_wb_rs", 8'(result_src), 8'b01);
    cyc();
    check_eq("lw_s0", 8'(state_o), 8'd0);

    // Fetch stall for 3 cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_state", 8'(state_o), 8'd0);
      check_eq("stall_en", 8'(en), 8'b100000);
      if (i < 2) cyc();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("stall_done_en", 8'(en), 8'b110010);

    // bne, zero=0: taken
    op = 7'b1100011; funct3 = 3'b001; zero = 1'b0;
    cyc();
    check_eq("bne_imm", 8'(imm_src), 8'b10);
    cyc();
    check_eq("bne_s10", 8'(state_o), 8'd10);
    check_eq("bne_taken_en", 8'(en), 8'b010000);
    check_eq("bne_aluop", 8'(alu_op), 8'b01);
    check_eq("bne_a", 8'(alu_src_a), 8'b10);
    cyc();
    check_eq("bne_back", 8'(state_o), 8'd0);

    // bne, zero=1: not taken
    cyc();
    cyc();
    zero = 1'b1;
    #1;
    check_eq("bne_nt_s10", 8'(state_o), 8'd10);
    check_eq("bne_nt_en", 8'(en), 8'h00);
    check_eq("bne_nt_aluop", 8'(alu_op), 8'b01);

    // beq, zero=1: taken
    cyc();
    funct3 = 3'b000;
    cyc();
    cyc();
    check_eq("beq_s10", 8'(state_o), 8'd10);
    check_eq("beq_en", 8'(en), 8'b010000);
    cyc();

    // R-type
    op = 7'b0110011;
    cyc();
    cyc();
    check_eq("r_s6", 8'(state_o), 8'd6);
    check_eq("r_ctl", 8'({alu_src_a, alu_src_b, alu_op}), 8'b100010);
    check_eq("r_en", 8'(en), 8'h00);
    cyc();
    check_eq("r_s8", 8'(state_o), 8'd8);
    check_eq("r_wb_en", 8'(en), 8'b000001);
    cyc();
    check_eq("r_s0", 8'(state_o), 8'd0);

    // jal
    op = 7'b1101111;
    #1;
    check_eq("jal_imm", 8'(imm_src), 8'b11);
    cyc();
    cyc();
    check_eq("jal_s9", 8'(state_o), 8'd9);
    check_eq("jal_en", 8'(en), 8'b010000);
    check_eq("jal_ctl", 8'({alu_src_a, alu_src_b, result_src}), 8'b011000);
    cyc();
    check_eq("jal_s8", 8'(state_o), 8'd8);
    cyc();

    // sw with 2 wait cycles
    op = 7'b0100011;
    cyc();
    check_eq("sw_imm", 8'(imm_src), 8'b01);
    cyc();
    check_eq("sw_s2", 8'(state_o), 8'd2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) mem_ready = 1'b1;
      #1;
      check_eq("sw_s5", 8'(state_o), 8'd5);
      check_eq("sw_en", 8'(en), 8'b101100);
    end
    cyc();
    check_eq("sw_s0", 8'(state_o), 8'd0);

    // Trap on unsupported opcode
    op = 7'b1110011;
    cyc();
    cyc();
    check_eq("trap_s11", 8'(state_o), 8'd11);
    check_eq("trap_flag", 8'(illegal_instr), 8'd1);
    check_eq("trap_en", 8'(en), 8'h00);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      zero = i[1];
      cyc();
      check_eq("trap_hold", 8'({illegal_instr, state_o, en[5:3]}), {1'b1, 4'd11, 3'b000});
      check_eq("trap_hold_en", 8'(en), 8'h00);
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    cyc();
    check_eq("trap_rst_flag", 8'(illegal_instr), 8'd0);
    check_eq("trap_rst_state", 8'(state_o), 8'd0);
    check_eq("trap_rst_en", 8'(en), 8'h00);
    rst_n = 1'b1;
    #1;
    check_eq("trap_rel_req", 8'(mem_req), 8'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
